// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, reset PC
// and the opcodes the bench uses to build branch/jump words.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_BEQ = 6'b000100;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Sequential and redirect target computation for the fetch stage.
// A jump keeps the upper nibble of pc+4; a branch adds the sign-extended
// word offset to pc+4 with plain 32-bit wrap.
module fetch_unit_next_pc (
  input  logic [31:0] pc,
  input  logic [25:0] instr_index,
  input  logic        dojump,
  output logic [31:0] pcplus4,
  output logic [31:0] target
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;

  // Both candidate targets are formed every cycle; dojump selects the jump
  always_comb begin
    pcplus4       = pc + 32'd4;
    jump_target   = {pcplus4[31:28], instr_index, 2'b00};
    branch_target = pcplus4 + {{14{instr_index[15]}}, instr_index[15:0], 2'b00};
    target        = dojump ? jump_target : branch_target;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and hands
// one instruction at a time to the decoder with a valid/ready handshake.
// A single prefetch slot holds the word at pc+4 so sequential code can
// retire one instruction per cycle when memory keeps up.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        dobranch,
  input  logic        dojump,
  output logic [31:0] pc,
  output logic [31:0] pcplus4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pf_data_q, pf_data_d;
  logic         pf_full_q, pf_full_d;

  logic [31:0]  pcplus4_w;
  logic [31:0]  target_w;
  logic         transfer;
  logic         retire;
  logic         redirect;

  fetch_unit_next_pc u_next_pc (
    .pc          (pc_q),
    .instr_index (instr_q[25:0]),
    .dojump      (dojump),
    .pcplus4     (pcplus4_w),
    .target      (target_w)
  );

  // State and datapath registers; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      pf_data_q <= 32'd0;
      pf_full_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pf_data_q <= pf_data_d;
      pf_full_q <= pf_full_d;
    end
  end

  // Handshake outputs depend only on state, pc and pf_full (never on ack);
  // they are forced low while reset is asserted so a mid-run reset is quiet
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    instr_valid = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_REQ: begin
          imem_req = 1'b1;
        end
        ST_VALID: begin
          instr_valid = 1'b1;
          imem_req    = !pf_full_q;
          imem_addr   = pcplus4_w;
        end
        default: begin
        end
      endcase
    end
  end

  assign transfer = imem_req & imem_ack;
  assign retire   = instr_valid & instr_ready;
  assign redirect = dojump | dobranch;

  // Next-state logic: fetch, retire, prefetch capture and redirect handling
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pf_data_d = pf_data_q;
    pf_full_d = pf_full_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (transfer) begin
          instr_d = imem_rdata;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (retire) begin
          if (redirect) begin
            pc_d      = target_w;
            pf_full_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            pc_d = pcplus4_w;
            if (pf_full_q) begin
              instr_d   = pf_data_q;
              pf_full_d = 1'b0;
            end else if (transfer) begin
              instr_d = imem_rdata;
            end else begin
              state_d = ST_REQ;
            end
          end
        end else if (transfer) begin
          pf_full_d = 1'b1;
          pf_data_d = imem_rdata;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign instr   = instr_q;
  assign pc      = pc_q;
  assign pcplus4 = pcplus4_w;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle MIPS core. It sits directly upstream of the instruction decoder. It owns the program counter and issues word reads to instruction memory. It presents one instruction at a time to the decoder/datapath with a valid/ready handshake, and redirects on the decoder's `dobranch`/`dojump`. A one-entry prefetch of PC+4 gives zero-bubble sequential flow when memory answers in time.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC after reset; must be word-aligned.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `imem_addr`  out  32: word address of the current memory request.
- `imem_req`  out  1: memory request valid.
- `imem_ack`  in  1: memory returns `imem_rdata` for `imem_addr` this cycle. It may be combinational on the address.
- `imem_rdata`  in  32: read data, meaningful only when `imem_req & imem_ack`.
- `instr`  out  32: instruction word to the decoder.
- `instr_valid`  out  1: `instr`, `pc` and `pcplus4` are valid.
- `instr_ready`  in  1: the datapath retires `instr` this cycle.
- `dobranch`  in  1: decoder branch-taken; sampled only on retire.
- `dojump`  in  1: decoder absolute jump; sampled only on retire.
- `pc`  out  32: address of `instr`.
- `pcplus4`  out  32: `pc + 4`.

## Operation
- A transfer occurs in any cycle with `imem_req & imem_ack`. Memory is stateless across cycles. Dropping `imem_req` or changing `imem_addr` without an ack aborts the request, and this is legal.
- A retire is a cycle with `instr_valid & instr_ready`. `instr_ready` without `instr_valid` is ignored.
- States:
  - IDLE: reset state; `imem_req=0`; always moves to REQ next cycle.
  - REQ: `imem_req=1`, `imem_addr=pc`, `instr_valid=0`. On transfer: `instr<=imem_rdata`, go to VALID.
  - VALID: `instr_valid=1`.
    - If `pf_full=0`: `imem_req=1`, `imem_addr=pc+4`.
    - If `pf_full=1`: `imem_req=0`.
    - A transfer that is not a retire sets `pf_full<=1`, `pf_data<=imem_rdata`.
- Retire with redirect (`dojump` or `dobranch`):
  - `dojump` has priority: target = `{pcplus4[31:28], instr[25:0], 2'b00}`.
  - `dobranch`: target = `pcplus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`, 32-bit wrap.
  - Then `pc<=target`, `pf_full<=0`, go to REQ. A prefetch transfer in the same cycle is discarded.
- Retire, sequential:
  - `pc<=pc+4`, 32-bit wrap from 32'hFFFF_FFFC to 0.
  - If `pf_full`: `instr<=pf_data`, `pf_full<=0`, stay in VALID.
  - Else if prefetch transfer this cycle: `instr<=imem_rdata`, stay in VALID.
  - Else go to REQ. The next request targets the new `pc`, which is the same address as the aborted prefetch.
- `pcplus4 = pc + 4`, combinational.
- Reset values: state IDLE, `pc=RESET_PC`, `instr=0`, `pf_data=0`, `pf_full=0`. Outputs during reset: `instr_valid=0`, `imem_req=0`.
- Reset mid-operation: everything is discarded and the next fetch is from `RESET_PC`.

## Timing
- First `imem_req` is in the first cycle after `reset_n` rises.
- Fetch latency: `instr_valid` rises the cycle after the REQ transfer. With 0-wait memory this is 2 cycles after reset release.
- Sequential throughput: 1 instruction/cycle when the prefetch has transferred by the retire cycle.
- Redirect penalty: `instr_valid=0` for at least one cycle (the REQ cycle) after a redirect retire.
- `instr`, `pc` and `instr_valid` are registered. `imem_req`/`imem_addr` are combinational from state, `pc` and `pf_full` only. They never depend on `imem_ack`.

## Structure
- Shared include `mips_defs.vh` holds:
  - state encodings (IDLE/REQ/VALID, 2 bits)
  - the `RESET_PC` default
  - opcode constants for J and BEQ used by the bench.
- One natural sub-module, `next_pc`: combinational branch/jump target computation from `pc` and `instr`.

## Test plan
- Reset release with 0-wait memory returning `addr` as data → `imem_addr` 0x00400000, then 0x00400004. `instr_valid` high on cycle 2. Continuous `instr_ready` gives a consecutive `pc` every cycle.
- Memory with 3 wait cycles, `instr_ready` held high → `instr_valid` pulses every 4 cycles. `pc` increments by 4. No instruction is skipped or duplicated.
- At `pc=0x00400008`, `instr[15:0]=16'hFFFE`, `dobranch=1` on retire → next `pc=0x00400004`. The prefetched word for 0x0040000C is discarded.
- At `pc=0x00400010`, `instr[25:0]=26'h0100020`, `dojump=1` (with `dobranch=1` also) → next `pc=0x00400080`.
- `instr_ready=0` for 5 cycles with the prefetch completed → `imem_req` low after the prefetch transfer. On release, the next `instr` follows with no bubble.
- `reset_n` low for one cycle during a pending request → `instr_valid=0` and `imem_req=0` in the reset cycle. The next request is at 0x00400000.
